// File: rtl/fuzzifier_mc.sv
`default_nettype none
// ============================================================================
// fuzzifier_mc : seven-set triangular fuzzifier, two-stage pipeline, tagged
// channels. Define FUZZ_CHANGE_DET_EN for per-channel dominant-set change flags.
// Revision: 1.0
// ============================================================================
module fuzzifier_mc #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2,
  parameter int DATA_W    = 16,
  parameter int BASE      = 0,
  parameter int STEP_LOG2 = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [CH_W-1:0]   IN_CH,
  input  logic [DATA_W-1:0] IN_CRISP,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CH_W-1:0]   OUT_CH,
  output logic [55:0]       OUT_DEG,
  output logic [7:0]        OUT_SET_ID,
  output logic [7:0]        OUT_MAX_DEG,
  output logic              OUT_CHANGE
);

  localparam logic [DATA_W-1:0] c_BASE = DATA_W'(BASE);

  logic                 w_adv;
  logic                 r_s1_valid;
  logic [CH_W-1:0]      r_s1_ch;
  logic [DATA_W-1:0]    r_s1_x;
  logic [DATA_W-1:0]    w_d;
  logic [DATA_W-1:0]    w_idx;
  logic [STEP_LOG2-1:0] w_frac;
  logic [2:0]           w_idx3;
  logic [7:0]           w_f8;
  logic [7:0]           w_deg [7];
  logic [55:0]          w_deg_flat;
  logic [7:0]           w_id;
  logic [7:0]           w_max;
  logic                 w_change;

  assign w_adv    = !(OUT_VALID && !OUT_READY);
  assign IN_READY = w_adv || !RST_N;

  always_comb begin
    w_d    = r_s1_x - c_BASE;
    w_idx  = w_d >> STEP_LOG2;
    w_frac = w_d[STEP_LOG2-1:0];
    w_idx3 = w_idx[2:0];
    w_f8   = 8'(({8'd0, w_frac} * (STEP_LOG2 + 8)'(255)) >> STEP_LOG2);
    for (int k = 0; k < 7; k++) w_deg[k] = 8'd0;
    if (r_s1_x < c_BASE) begin
      w_deg[0] = 8'd255;
    end else if (w_idx >= DATA_W'(6)) begin
      w_deg[6] = 8'd255;
    end else begin
      w_deg[w_idx3]        = 8'd255 - w_f8;
      w_deg[w_idx3 + 3'd1] = w_f8;
    end
    // Strict compare keeps the lower ID on ties.
    w_max = w_deg[0];
    w_id  = 8'd1;
    for (int k = 1; k < 7; k++) begin
      if (w_deg[k] > w_max) begin
        w_max = w_deg[k];
        w_id  = 8'(k + 1);
      end
    end
    w_deg_flat = '0;
    for (int k = 0; k < 7; k++) w_deg_flat[8*k +: 8] = w_deg[k];
  end

`ifdef FUZZ_CHANGE_DET_EN
  logic [7:0] r_hist_id   [NUM_CH];
  logic       r_hist_seen [NUM_CH];
  logic       w_s1_in_rng;
  logic       w_out_in_rng;
  logic [7:0] w_last_id;
  logic       w_last_seen;

  assign w_s1_in_rng  = int'(r_s1_ch) < NUM_CH;
  assign w_out_in_rng = int'(OUT_CH) < NUM_CH;

  // Stage 2 only loads when any held result is leaving this same edge, so a
  // matching result in the output register is the freshest history.
  always_comb begin
    w_last_id   = 8'd0;
    w_last_seen = 1'b0;
    if (OUT_VALID && (OUT_CH == r_s1_ch)) begin
      w_last_id   = OUT_SET_ID;
      w_last_seen = 1'b1;
    end else if (w_s1_in_rng) begin
      w_last_id   = r_hist_id[r_s1_ch];
      w_last_seen = r_hist_seen[r_s1_ch];
    end
  end

  assign w_change = w_s1_in_rng && (!w_last_seen || (w_last_id != w_id));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_hist_id[i]   <= 8'd0;
        r_hist_seen[i] <= 1'b0;
      end
    end else if (OUT_VALID && OUT_READY && w_out_in_rng) begin
      r_hist_id[OUT_CH]   <= OUT_SET_ID;
      r_hist_seen[OUT_CH] <= 1'b1;
    end
  end
`else
  assign w_change = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_s1_valid  <= 1'b0;
      r_s1_ch     <= '0;
      r_s1_x      <= '0;
      OUT_VALID   <= 1'b0;
      OUT_CH      <= '0;
      OUT_DEG     <= '0;
      OUT_SET_ID  <= 8'd0;
      OUT_MAX_DEG <= 8'd0;
      OUT_CHANGE  <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= IN_VALID;
      if (IN_VALID) begin
        r_s1_ch <= IN_CH;
        r_s1_x  <= IN_CRISP;
      end
      OUT_VALID <= r_s1_valid;
      if (r_s1_valid) begin
        OUT_CH      <= r_s1_ch;
        OUT_DEG     <= w_deg_flat;
        OUT_SET_ID  <= w_id;
        OUT_MAX_DEG <= w_max;
        OUT_CHANGE  <= w_change;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/fuzzifier_mc.md
FUZZIFIER_MC -- requirements
Module: fuzzifier_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of logical input channels, legal range 1..16.
REQ-002 SHALL have parameter CH_W, default 2: channel-tag width; 2^CH_W >= NUM_CH.
REQ-003 SHALL have parameter DATA_W, default 16: unsigned crisp input width.
REQ-004 SHALL have parameter BASE, default 0: centre of set 1, in DATA_W-bit unsigned.
REQ-005 SHALL have parameter STEP_LOG2, default 4: centre spacing is 2^STEP_LOG2, legal range 1..8.
REQ-006 SHALL have ports, clock and reset first:
  CLK  in  1  rising-edge clock; one clock, synchronous reset, active-low
  RST_N  in  1  synchronous active-low reset
  IN_VALID  in  1  input sample valid
  IN_READY  out  1  block accepts a sample this cycle
  IN_CH  in  CH_W  channel tag of the sample
  IN_CRISP  in  DATA_W  crisp value
  OUT_VALID  out  1  result valid
  OUT_READY  in  1  downstream accepts the result
  OUT_CH  out  CH_W  channel tag of the result
  OUT_DEG  out  56  seven 8-bit degrees; set k (ID k+1) at bits [8k+7:8k]
  OUT_SET_ID  out  8  dominant set ID, 1..7
  OUT_MAX_DEG  out  8  degree of the dominant set
  OUT_CHANGE  out  1  dominant ID differs from the previous result on this channel

Function
REQ-007 SHALL use seven triangular sets with centres c_k = BASE + k*2^STEP_LOG2, k=0..6; set 1 is a left shoulder and set 7 a right shoulder.
REQ-008 SHALL compute: x < BASE -> set 1 = 255, all others 0; otherwise d = x-BASE, idx = d>>STEP_LOG2, frac = low STEP_LOG2 bits of d.
REQ-009 SHALL compute, for idx >= 6: set 7 = 255, all others 0.
REQ-010 SHALL compute, for idx < 6: f8 = (frac*255)>>STEP_LOG2 (truncating); set idx+1 = 255-f8; set idx+2 = f8; all others 0.
REQ-011 SHALL make OUT_SET_ID the set with the largest degree, with ties going to the lower ID; OUT_MAX_DEG SHALL be that degree.
REQ-012 SHALL be a two-stage pipeline: stage 1 registers the input, stage 2 registers the computed result. Latency from the accepting edge to OUT_VALID is exactly 2 cycles when unstalled.
REQ-013 SHALL advance when adv = !(OUT_VALID && !OUT_READY); IN_READY = adv.
REQ-014 SHALL accept a sample only on IN_VALID && IN_READY; IN_CH and IN_CRISP SHALL be ignored otherwise.
REQ-015 SHALL hold OUT_* stable while OUT_VALID && !OUT_READY; no sample SHALL be lost or duplicated under backpressure.
REQ-016 SHALL sustain one sample per cycle when OUT_READY is held high.
REQ-017 SHALL carry the channel tag unchanged through the pipeline; IN_CH >= NUM_CH SHALL pass through with OUT_CHANGE = 0 and no history update.
REQ-018 SHALL keep a per-channel history: last dominant ID plus a seen bit.
  - OUT_CHANGE = 1 if the seen bit is clear, or the ID differs from the last ID.
  - History SHALL update when a result leaves stage 2 (OUT_VALID && OUT_READY).
REQ-019 SHALL handle back-to-back samples on the same channel using the result just committed, not stale history.

Reset
REQ-020 SHALL, while RST_N = 0 at a rising edge:
  - clear both stage-valid bits;
  - set OUT_VALID = 0, OUT_DEG = 0, OUT_SET_ID = 0, OUT_MAX_DEG = 0, OUT_CH = 0, OUT_CHANGE = 0;
  - clear all history IDs and seen bits.
REQ-021 SHALL hold IN_READY = 1 during and after reset.
REQ-022 SHALL discard any in-flight samples when reset is asserted mid-operation; the first result after release SHALL come from a post-reset sample.

Configuration
REQ-023 SHALL compile the change-detection logic only when macro FUZZ_CHANGE_DET_EN is defined: REQ-018, REQ-019 and the history registers.
REQ-024 SHALL, without FUZZ_CHANGE_DET_EN, tie OUT_CHANGE to 0 and instantiate no history storage; all other behaviour is unchanged.

Verification (BASE=0, STEP_LOG2=4, NUM_CH=4)
REQ-025 SHALL check: IN_CRISP=24, ch0 -> 2 cycles later: ID2=128, ID3=127, others 0; OUT_SET_ID=2; OUT_MAX_DEG=128; OUT_CHANGE=1.
REQ-026 SHALL check: IN_CRISP=0, 16, 100, 65535 -> ID1=255; ID2=255 (ID3=0); ID7=255; ID7=255.
REQ-027 SHALL check tie and change detection: IN_CRISP=8 -> f8=127, ID1=128, OUT_SET_ID=1. Then IN_CRISP=9 on the same channel -> ID1=112, ID2=143, OUT_SET_ID=2, OUT_CHANGE=1. A repeat of 9 -> OUT_CHANGE=0 (macro defined); 0 always (macro undefined).
REQ-028 SHALL check backpressure: OUT_READY=0 for 5 cycles during a 6-sample burst. Required: IN_READY falls, outputs are held, and all 6 results appear in order with no loss.
REQ-029 SHALL check reset mid-burst: RST_N=0 for 1 cycle with 2 samples in flight. Required: OUT_VALID=0 next cycle; neither sample emerges; the next sample on any channel gives OUT_CHANGE=1.
